jimmy_out_capture_fifo: RTL and testbench

- Downstream consumer of the CPU core's four output ports.
- Watches the active-low one-cycle `out_strobe[3:0]` pulses and captures `{port_id, data}` for each OUTPUT instruction into a circular FIFO.
- Presents the captured entries on a valid/ready drain interface for a UART bridge, LED driver or testbench scoreboard.
- Keeps a full/empty/count status and a saturating drop counter, so software writes lost to back-pressure are visible.

---
 rtl/jimmy_io_pkg.sv | 22 ++
 rtl/jimmy_sync_fifo.sv | 76 +++++++
 rtl/jimmy_out_capture_fifo.sv | 141 ++++++++++++++
 tb/tb_jimmy_out_capture_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jimmy_io_pkg.sv
// Shared types and constants for the CPU output-port capture path.
// Optional macro JIMMY_OUT_TIMESTAMP_EN adds a 16-bit capture stamp to each entry.
package jimmy_io_pkg;

  localparam int PORT_W   = 2;
  localparam int DATA_W   = 8;
  localparam int TSTAMP_W = 16;

  // The core pulls a strobe low for one cycle per OUTPUT instruction
  localparam logic STROBE_ACTIVE = 1'b0;

  typedef struct packed {
    logic [PORT_W-1:0]   port;
    logic [DATA_W-1:0]   data;
`ifdef JIMMY_OUT_TIMESTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`else
    // Without stamps an entry is just {port, data}, 10 bits
`endif
  } out_entry_t;

endpackage

// File: rtl/jimmy_sync_fifo.sv
// Generic circular buffer of out_entry_t with registered count/full/empty.
// Head is read combinationally from storage; it reads as zero while empty.
module jimmy_sync_fifo
  import jimmy_io_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  out_entry_t       entry_i,
  input  logic             pop_i,
  output out_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  out_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             popOk;
  logic             pushOk;

  // A push into a full buffer is legal only when the head leaves in the same cycle
  always_comb begin
    popOk   = pop_i && !empty_q;
    pushOk  = push_i && (!full_q || popOk);
    rdPtr_d = popOk  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    wrPtr_d = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    count_d = count_q;
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Entry storage; contents need no reset because the head is masked while empty
  always_ff @(posedge clk_i) begin
    if (pushOk && !reset_i) begin
      mem_q[wrPtr_q] <= entry_i;
    end
  end

  assign head_o  = empty_q ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/jimmy_out_capture_fifo.sv
// Captures {port, data} on each falling edge of the CPU output strobes into a FIFO
// and drains it over valid/ready, with drop statistics for back-pressure losses.
// Optional macro JIMMY_OUT_TIMESTAMP_EN adds a free-running stamp and m_tstamp.
module jimmy_out_capture_fifo
  import jimmy_io_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             jimmy_clk,
  input  logic             reset,
  input  logic [7:0]       out_port_0,
  input  logic [7:0]       out_port_1,
  input  logic [7:0]       out_port_2,
  input  logic [7:0]       out_port_3,
  input  logic [3:0]       out_strobe,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_port,
  output logic [7:0]       m_data,
`ifdef JIMMY_OUT_TIMESTAMP_EN
  output logic [15:0]      m_tstamp,
`endif
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [7:0]       drop_count,
  input  logic             clr_stats
);

  logic [3:0] prevN_q;
  logic [3:0] events;
  logic       anyEvent;
  logic [1:0] selPort;
  logic [7:0] selData;
  logic [2:0] numEvents;
  logic       pop;
  logic       blocked;
  logic [2:0] dropsNow;
  logic [8:0] dropSum;
  logic [7:0] dropCount_q, dropCount_d;
  logic       overflow_q, overflow_d;
  logic       fifoFull;
  logic       fifoEmpty;
  out_entry_t pushEntry;
  out_entry_t headEntry;

  // Falling-edge detect per strobe; a strobe held low only counts once
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      events[i] = (out_strobe[i] == STROBE_ACTIVE) && (prevN_q[i] != STROBE_ACTIVE);
    end
  end

  // Lowest-index event wins the push slot; the others become drops
  always_comb begin
    selPort   = '0;
    numEvents = '0;
    for (int i = 3; i >= 0; i--) begin
      if (events[i]) selPort = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      numEvents = numEvents + 3'(events[i]);
    end
    case (selPort)
      2'd0:    selData = out_port_0;
      2'd1:    selData = out_port_1;
      2'd2:    selData = out_port_2;
      default: selData = out_port_3;
    endcase
  end

  assign anyEvent = |events;
  assign m_valid  = !fifoEmpty;
  assign pop      = m_valid && m_ready;
  assign blocked  = anyEvent && fifoFull && !pop;

  // Count losing simultaneous events plus a push refused by a full buffer; clear wins
  always_comb begin
    dropsNow    = anyEvent ? (numEvents - 3'd1) + {2'b00, blocked} : 3'd0;
    dropSum     = {1'b0, dropCount_q} + {6'b0, dropsNow};
    dropCount_d = (dropSum > 9'd255) ? 8'hFF : dropSum[7:0];
    overflow_d  = overflow_q || (dropsNow != 3'd0);
    if (clr_stats) begin
      dropCount_d = '0;
      overflow_d  = 1'b0;
    end
  end

  // Strobe history and drop statistics
  always_ff @(posedge jimmy_clk) begin
    if (reset) begin
      prevN_q     <= 4'b0000;
      dropCount_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prevN_q     <= out_strobe;
      dropCount_q <= dropCount_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef JIMMY_OUT_TIMESTAMP_EN
  logic [TSTAMP_W-1:0] stamp_q;

  // Free-running cycle counter sampled into each captured entry
  always_ff @(posedge jimmy_clk) begin
    if (reset) stamp_q <= '0;
    else       stamp_q <= stamp_q + TSTAMP_W'(1);
  end

  assign pushEntry = '{port: selPort, data: selData, tstamp: stamp_q};
  assign m_tstamp  = headEntry.tstamp;
`else
  assign pushEntry = '{port: selPort, data: selData};
`endif

  jimmy_sync_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) uFifo (
    .clk_i   (jimmy_clk),
    .reset_i (reset),
    .push_i  (anyEvent),
    .entry_i (pushEntry),
    .pop_i   (pop),
    .head_o  (headEntry),
    .count_o (count),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign m_port     = headEntry.port;
  assign m_data     = headEntry.data;
  assign full       = fifoFull;
  assign empty      = fifoEmpty;
  assign overflow   = overflow_q;
  assign drop_count = dropCount_q;

endmodule

// File: tb/tb_jimmy_out_capture_fifo.sv
// Self-checking bench for jimmy_out_capture_fifo: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_jimmy_out_capture_fifo;

  localparam int DEPTH = 8;

  logic       jimmy_clk;
  logic       reset;
  logic [7:0] out_port_0, out_port_1, out_port_2, out_port_3;
  logic [3:0] out_strobe;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_port;
  logic [7:0] m_data;
  logic [3:0] count;
  logic       full, empty, overflow;
  logic [7:0] drop_count;
  logic       clr_stats;
`ifdef JIMMY_OUT_TIMESTAMP_EN
  logic [15:0] m_tstamp;
`endif

  jimmy_out_capture_fifo #(.DEPTH(DEPTH)) dut (
    .jimmy_clk  (jimmy_clk),
    .reset      (reset),
    .out_port_0 (out_port_0),
    .out_port_1 (out_port_1),
    .out_port_2 (out_port_2),
    .out_port_3 (out_port_3),
    .out_strobe (out_strobe),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_port     (m_port),
    .m_data     (m_data),
`ifdef JIMMY_OUT_TIMESTAMP_EN
    .m_tstamp   (m_tstamp),
`endif
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clr_stats  (clr_stats)
  );

  initial jimmy_clk = 1'b0;
  always #5 jimmy_clk = ~jimmy_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a plain queue of captured entries plus statistics
  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } ent_t;

  ent_t       mq[$];
  int         mDrop = 0;
  bit         mOvf = 0;
  logic [3:0] mPrev = 4'b0000;

  typedef struct {
    logic       rst;
    logic [3:0] strobe;
    logic [7:0] p0, p1, p2, p3;
    logic       ready;
    logic       clr;
    logic       expValid;
    logic [1:0] expPort;
    logic [7:0] expData;
    int         expCount;
    int         expDrop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] portVal(input int i);
    case (i)
      0:       return out_port_0;
      1:       return out_port_1;
      2:       return out_port_2;
      default: return out_port_3;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelEdge();
    int nev;
    int first;
    int drops;
    bit doPop;
    if (reset) begin
      mq.delete();
      mDrop = 0;
      mOvf  = 0;
      mPrev = 4'b0000;
      return;
    end
    nev = 0;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      if (out_strobe[i] == 1'b0 && mPrev[i] == 1'b1) begin
        nev++;
        if (first < 0) first = i;
      end
    end
    doPop = (mq.size() > 0) && m_ready;
    drops = (nev > 0) ? nev - 1 : 0;
    if (doPop) void'(mq.pop_front());
    if (nev > 0) begin
      if (mq.size() < DEPTH) mq.push_back('{port: 2'(first), data: portVal(first)});
      else drops++;
    end
    if (clr_stats) begin
      mDrop = 0;
      mOvf  = 0;
    end else if (drops > 0) begin
      mDrop = (mDrop + drops > 255) ? 255 : mDrop + drops;
      mOvf  = 1;
    end
    mPrev = out_strobe;
  endtask

  task automatic checkOutput();
    check("model.m_valid", int'(m_valid), int'(mq.size() > 0));
    check("model.count", int'(count), mq.size());
    check("model.full", int'(full), int'(mq.size() == DEPTH));
    check("model.empty", int'(empty), int'(mq.size() == 0));
    check("model.overflow", int'(overflow), int'(mOvf));
    check("model.drop_count", int'(drop_count), mDrop);
    if (mq.size() > 0) begin
      check("model.m_port", int'(m_port), int'(mq[0].port));
      check("model.m_data", int'(m_data), int'(mq[0].data));
    end
  endtask

  // One clock: model consumes the driven inputs, DUT is sampled 1 unit after the edge
  task automatic step();
    modelEdge();
    @(posedge jimmy_clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] strobe, input logic ready,
                               input logic clr);
    reset      = rst;
    out_strobe = strobe;
    m_ready    = ready;
    clr_stats  = clr;
  endtask

  task automatic setPort(input int i, input logic [7:0] v);
    case (i)
      0:       out_port_0 = v;
      1:       out_port_1 = v;
      2:       out_port_2 = v;
      default: out_port_3 = v;
    endcase
  endtask

  task automatic pulse(input int i, input logic [7:0] v);
    logic [3:0] s;
    s = 4'b1111;
    s[i] = 1'b0;
    setPort(i, v);
    applyStimulus(1'b0, s, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    out_port_0 = '0; out_port_1 = '0; out_port_2 = '0; out_port_3 = '0;

    // rst strobe p0 p1 p2 p3 ready clr | valid port data count drop
    vecs.push_back('{1'b1, 4'b1111, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 0, 0});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 0, 0});
    vecs.push_back('{1'b0, 4'b1011, 8'h00, 8'h00, 8'h3B, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 8'h3B, 1, 0});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 8'h00, 8'h3B, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 0, 0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 4'b1101, 8'h00, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1, 0});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 8'h11, 1, 0});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 0, 0});
    vecs.push_back('{1'b0, 4'b0110, 8'hAA, 8'h00, 8'h00, 8'hBB, 1'b0, 1'b0, 1'b1, 2'd0, 8'hAA, 1, 1});
    vecs.push_back('{1'b0, 4'b1111, 8'hAA, 8'h00, 8'h00, 8'hBB, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 0, 1});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 0, 0});

    for (int v = 0; v < vecs.size(); v++) begin
      out_port_0 = vecs[v].p0; out_port_1 = vecs[v].p1;
      out_port_2 = vecs[v].p2; out_port_3 = vecs[v].p3;
      applyStimulus(vecs[v].rst, vecs[v].strobe, vecs[v].ready, vecs[v].clr);
      step();
      check($sformatf("vec%0d.m_valid", v), int'(m_valid), int'(vecs[v].expValid));
      check($sformatf("vec%0d.count", v), int'(count), vecs[v].expCount);
      check($sformatf("vec%0d.drop_count", v), int'(drop_count), vecs[v].expDrop);
      if (vecs[v].expValid) begin
        check($sformatf("vec%0d.m_port", v), int'(m_port), int'(vecs[v].expPort));
        check($sformatf("vec%0d.m_data", v), int'(m_data), int'(vecs[v].expData));
      end
      if (vecs[v].rst) begin
        check("reset.m_port", int'(m_port), 0);
        check("reset.m_data", int'(m_data), 0);
        check("reset.overflow", int'(overflow), 0);
        check("reset.empty", int'(empty), 1);
      end
    end

    // Fill to full with ready low, then one more write is dropped
    for (int k = 0; k < 8; k++) pulse(k % 4, 8'(3 + k));
    check("fill.full", int'(full), 1);
    check("fill.count", int'(count), 8);
    pulse(0, 8'hEE);
    check("ovf.drop_count", int'(drop_count), 1);
    check("ovf.overflow", int'(overflow), 1);
    check("ovf.count", int'(count), 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d.m_data", k), int'(m_data), 3 + k);
      check($sformatf("drain%0d.m_port", k), int'(m_port), k % 4);
      applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
      step();
    end
    check("drain.empty", int'(empty), 1);

    // Full buffer with push and pop in the same cycle
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 8; k++) pulse(k % 4, 8'(8'h40 + k));
    check("pp.head_before", int'(m_data), 8'h40);
    setPort(0, 8'h99);
    applyStimulus(1'b0, 4'b1110, 1'b1, 1'b0);
    step();
    check("pp.count", int'(count), 8);
    check("pp.drop_count", int'(drop_count), 0);
    check("pp.head_after", int'(m_data), 8'h41);

    // Reset with five queued entries; a strobe in the reset cycle is ignored
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) pulse(k, 8'(8'h50 + k));
    out_port_0 = 8'h60; out_port_1 = 8'h61;
    applyStimulus(1'b0, 4'b1100, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    step();
    check("prerst.count", int'(count), 5);
    check("prerst.drop_count", int'(drop_count), 1);
    out_port_1 = 8'h77;
    applyStimulus(1'b1, 4'b1101, 1'b0, 1'b0);
    step();
    check("rst.count", int'(count), 0);
    check("rst.m_valid", int'(m_valid), 0);
    check("rst.drop_count", int'(drop_count), 0);
    applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    step();
    check("postrst.count", int'(count), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0] s;
      for (int i = 0; i < 4; i++) s[i] = ($urandom_range(0, 2) != 0);
      out_port_0 = 8'($urandom); out_port_1 = 8'($urandom);
      out_port_2 = 8'($urandom); out_port_3 = 8'($urandom);
      applyStimulus(($urandom_range(0, 149) == 0), s, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 31) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
